// File: rtl/rr_mux_pkg.sv
// Shared constants for the rr_mux buffered multiplexer stage.
package rr_mux_pkg;
    localparam logic MODE_FIXED   = 1'b0;
    localparam logic MODE_RR      = 1'b1;
    localparam int   DEF_WIDTH    = 8;
    localparam int   DEF_CHANNELS = 4;
endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority find-first: grants the first requester after ptr, wrapping modulo CHANNELS.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic                gnt_valid,
    output logic [SEL_W-1:0]    gnt_idx
);

    logic [SEL_W-1:0] scan_idx_s;

    // Scan farthest-to-nearest so the nearest requester after ptr is written last and wins.
    always_comb begin
        gnt_valid  = 1'b0;
        gnt_idx    = {SEL_W{1'b0}};
        scan_idx_s = {SEL_W{1'b0}};
        for (int k = CHANNELS; k >= 1; k--) begin
            scan_idx_s = SEL_W'((int'(ptr) + k) % CHANNELS);
            gnt_valid  = gnt_valid | req[scan_idx_s];
            gnt_idx    = req[scan_idx_s] ? scan_idx_s : gnt_idx;
        end
    end

endmodule

// File: rtl/rr_mux.sv
// Registered N-channel mux with valid/ready handshakes, fixed-select or round-robin grant.
// Define RR_MUX_COUNT_EN to add the saturating xfer_count output-transfer counter.
module rr_mux
    import rr_mux_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          select,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_channel,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef RR_MUX_COUNT_EN
    ,
    output logic [15:0]               xfer_count
`endif
);

    localparam int EXT_N = 1 << SEL_W;

    logic [WIDTH-1:0]   out_data_r;
    logic [SEL_W-1:0]   out_channel_r;
    logic               out_valid_r;
    logic [SEL_W-1:0]   ptr_r;

    logic               load_s;
    logic               xfer_s;
    logic               arb_valid_s;
    logic [SEL_W-1:0]   arb_idx_s;
    logic               gnt_valid_s;
    logic [SEL_W-1:0]   gnt_idx_s;
    logic [EXT_N-1:0]   valid_ext_s;
    logic [WIDTH-1:0]   data_sel_s;

    rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
        .req       (in_valid),
        .ptr       (ptr_r),
        .gnt_valid (arb_valid_s),
        .gnt_idx   (arb_idx_s)
    );

    // Grant selection, handshake and data steering; padding valid to 2**SEL_W makes out-of-range selects ungranted.
    always_comb begin
        valid_ext_s                 = {EXT_N{1'b0}};
        valid_ext_s[CHANNELS-1:0]   = in_valid;
        load_s                      = ~out_valid_r | out_ready;
        if (mode == MODE_RR) begin
            gnt_valid_s = arb_valid_s;
            gnt_idx_s   = arb_idx_s;
        end else begin
            gnt_valid_s = valid_ext_s[select];
            gnt_idx_s   = select;
        end
        xfer_s     = load_s & gnt_valid_s & ~reset;
        in_ready   = {CHANNELS{1'b0}};
        data_sel_s = {WIDTH{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = xfer_s & (gnt_idx_s == SEL_W'(i));
            data_sel_s  = (gnt_idx_s == SEL_W'(i)) ? in_data[i*WIDTH +: WIDTH] : data_sel_s;
        end
    end

    // Output register and round-robin pointer; a held word only changes when load is set.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_r    <= {WIDTH{1'b0}};
            out_channel_r <= {SEL_W{1'b0}};
            out_valid_r   <= 1'b0;
            ptr_r         <= SEL_W'(CHANNELS - 1);
        end else if (xfer_s) begin
            out_data_r    <= data_sel_s;
            out_channel_r <= gnt_idx_s;
            out_valid_r   <= 1'b1;
            if (mode == MODE_RR) begin
                ptr_r <= gnt_idx_s;
            end else begin
                ptr_r <= ptr_r;
            end
        end else if (load_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_data    = out_data_r;
    assign out_channel = out_channel_r;
    assign out_valid   = out_valid_r;

`ifdef RR_MUX_COUNT_EN
    logic [15:0] count_r;

    // Saturating count of words accepted by the consumer.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 16'h0000;
        end else if (out_valid_r && out_ready && (count_r != 16'hFFFF)) begin
            count_r <= count_r + 16'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign xfer_count = count_r;
`endif

endmodule

// File: tb/tb_rr_mux.sv
// Directed self-checking bench for rr_mux (WIDTH=8, CHANNELS=4).
module tb_rr_mux;
    import rr_mux_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic [1:0]  select;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_channel;
    logic        out_valid;
    logic        out_ready;
`ifdef RR_MUX_COUNT_EN
    logic [15:0] xfer_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    rr_mux #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .select      (select),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_channel (out_channel),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
`ifdef RR_MUX_COUNT_EN
        ,
        .xfer_count  (xfer_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ch_data(input int ch);
        logic [31:0] d;
        d = 32'hF00F55AA;
        return d[ch*8 +: 8];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; mode = MODE_RR; select = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 4'b0000) begin
            miscompares++; $display("FAIL reset_in_ready got %b want 0000", in_ready);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        vectors++;
        if (out_data !== 8'h00) begin
            miscompares++; $display("FAIL reset_out_data got %h want 00", out_data);
        end
        vectors++;
        if (out_channel !== 2'd0) begin
            miscompares++; $display("FAIL reset_out_channel got %0d want 0", out_channel);
        end
        reset = 1'b0;
    endtask

    task automatic test_fixed();
        logic [1:0] sel;
        mode = MODE_FIXED; in_valid = 4'hF; out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            sel = (t % 2 == 0) ? 2'd0 : 2'd1;
            select = sel;
            #1;
            vectors++;
            if (in_ready !== (4'b0001 << sel)) begin
                miscompares++; $display("FAIL fixed_in_ready got %b want %b", in_ready, 4'b0001 << sel);
            end
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== ch_data(int'(sel)) || out_channel !== sel) begin
                miscompares++;
                $display("FAIL fixed_out got v=%b d=%h c=%0d want v=1 d=%h c=%0d",
                         out_valid, out_data, out_channel, ch_data(int'(sel)), sel);
            end
            repeat (9) tick();
            vectors++;
            if (out_data !== ch_data(int'(sel))) begin
                miscompares++; $display("FAIL fixed_hold got %h want %h", out_data, ch_data(int'(sel)));
            end
        end
    endtask

    // Runs straight after fixed mode, so ptr must still hold its reset value.
    task automatic test_rr();
        int exp_ch;
        mode = MODE_RR; in_valid = 4'hF; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_ch = k % 4;
            #1;
            vectors++;
            if (in_ready !== (4'b0001 << exp_ch)) begin
                miscompares++; $display("FAIL rr_in_ready got %b want %b", in_ready, 4'b0001 << exp_ch);
            end
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_channel !== 2'(exp_ch) || out_data !== ch_data(exp_ch)) begin
                miscompares++;
                $display("FAIL rr_out got v=%b c=%0d d=%h want v=1 c=%0d d=%h",
                         out_valid, out_channel, out_data, exp_ch, ch_data(exp_ch));
            end
        end
    endtask

    task automatic test_skip_wrap();
        int exp_ch;
        mode = MODE_RR; in_valid = 4'b1010; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_ch = (k % 2 == 0) ? 1 : 3;
            tick();
            vectors++;
            if (out_channel !== 2'(exp_ch) || out_data !== ch_data(exp_ch)) begin
                miscompares++;
                $display("FAIL skip_out got c=%0d d=%h want c=%0d d=%h", out_channel, out_data, exp_ch, ch_data(exp_ch));
            end
        end
    endtask

    task automatic test_backpressure();
        mode = MODE_FIXED; select = 2'd1; in_valid = 4'hF; out_ready = 1'b1;
        tick();
        out_ready = 1'b0; select = 2'd2;
        for (int k = 0; k < 5; k++) begin
            #1;
            vectors++;
            if (in_ready !== 4'b0000) begin
                miscompares++; $display("FAIL bp_in_ready got %b want 0000", in_ready);
            end
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 8'h55 || out_channel !== 2'd1) begin
                miscompares++;
                $display("FAIL bp_hold got v=%b d=%h c=%0d want v=1 d=55 c=1", out_valid, out_data, out_channel);
            end
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 4'b0100) begin
            miscompares++; $display("FAIL bp_release_ready got %b want 0100", in_ready);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h0F || out_channel !== 2'd2) begin
            miscompares++;
            $display("FAIL bp_release got v=%b d=%h c=%0d want v=1 d=0f c=2", out_valid, out_data, out_channel);
        end
    endtask

    task automatic test_invalid_select_reset();
        mode = MODE_FIXED; select = 2'd3; in_valid = 4'b0111; out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 4'b0000) begin
            miscompares++; $display("FAIL badsel_in_ready got %b want 0000", in_ready);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL badsel_drain got v=%b want 0", out_valid);
        end
        // Move ptr to 1 and leave the stage FULL before resetting.
        mode = MODE_RR; in_valid = 4'b0010;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_channel !== 2'd1) begin
            miscompares++; $display("FAIL prereset_full got v=%b c=%0d want v=1 c=1", out_valid, out_channel);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_channel !== 2'd0) begin
            miscompares++;
            $display("FAIL midreset got v=%b d=%h c=%0d want v=0 d=00 c=0", out_valid, out_data, out_channel);
        end
        in_valid = 4'hF; out_ready = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_channel !== 2'd0 || out_data !== 8'hAA) begin
            miscompares++;
            $display("FAIL postreset_grant got v=%b c=%0d d=%h want v=1 c=0 d=aa", out_valid, out_channel, out_data);
        end
    endtask

`ifdef RR_MUX_COUNT_EN
    task automatic test_count();
        reset = 1'b1; tick(); reset = 1'b0;
        vectors++;
        if (xfer_count !== 16'h0000) begin
            miscompares++; $display("FAIL count_reset got %h want 0000", xfer_count);
        end
        mode = MODE_RR; in_valid = 4'hF; out_ready = 1'b1;
        repeat (70000) tick();
        vectors++;
        if (xfer_count !== 16'hFFFF) begin
            miscompares++; $display("FAIL count_sat got %h want ffff", xfer_count);
        end
        reset = 1'b1; tick(); reset = 1'b0;
        vectors++;
        if (xfer_count !== 16'h0000) begin
            miscompares++; $display("FAIL count_clear got %h want 0000", xfer_count);
        end
    endtask
`endif

    initial begin
        in_data = 32'hF00F55AA;
        reset = 1'b1; mode = MODE_FIXED; select = 2'd0; in_valid = 4'h0; out_ready = 1'b0;
        test_reset();
        test_fixed();
        test_rr();
        test_skip_wrap();
        test_backpressure();
        test_invalid_select_reset();
`ifdef RR_MUX_COUNT_EN
        test_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_mux.md
# rr_mux

Parametrised, registered N-channel multiplexer with valid/ready handshakes and two selection modes: an explicit select, or round-robin arbitration. It generalises the 8-bit two-input datapath mux into a buffered stage. It sits between multiple datapath producers (ALU result, memory read, immediate path) and a single consumer.

## Interface
- WIDTH, 8, data width per channel (≥1)
- CHANNELS, 4, number of input channels (≥2); SEL_W = $clog2(CHANNELS)
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-high reset
- mode  input  1  0 = fixed select, 1 = round-robin
- select  input  SEL_W  channel index used when mode = 0
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel valid
- in_ready  output  CHANNELS  per-channel ready (combinational)
- out_data  output  WIDTH  registered data
- out_channel  output  SEL_W  index of the channel that produced out_data
- out_valid  output  1  registered valid
- out_ready  input  1  consumer ready

## Operation
- Single output register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- load = !out_valid | out_ready. The stage accepts a new word only when load=1.
- Grant, fixed mode: grant = select if select < CHANNELS and in_valid[select]=1; otherwise no grant. The other channels are never ready.
- Grant, round-robin mode: scan from ptr+1 upward, modulo CHANNELS, and grant the first channel with in_valid=1. ptr ← granted index on each transfer. ptr is unchanged when there is no transfer.
- in_ready[i] = load & (grant == i). At most one bit is set.
- A transfer from channel i happens when in_valid[i] & in_ready[i]. On transfer: out_data ← channel i data, out_channel ← i, out_valid ← 1.
- If load=1 and there is no grant, out_valid ← 0.
- While FULL and out_ready=0: out_data, out_channel and out_valid hold, and all in_ready are 0.
- Simultaneous output drain and input transfer: both happen in the same cycle. EMPTY→FULL or FULL→FULL with no bubble.
- A mode or select change affects only the next arbitration. A word already held in the output register is never altered.
- Fixed mode does not update ptr.

## Timing
- Latency is 1 cycle, from an input transfer to the data appearing on out_data with out_valid=1.
- Throughput is 1 word per cycle when out_ready stays 1.
- in_ready depends combinationally on in_valid, mode, select, out_valid and out_ready. No input depends combinationally on out_* within this block.
- Reset values, applied on the clk edge while reset=1:
  - out_valid=0, out_data=0, out_channel=0
  - ptr=CHANNELS-1, so channel 0 has first priority
  - Optional counter = 0
- Reset asserted while FULL discards the held word. in_ready is forced to 0 while reset=1.
- Wrap-around: with ptr=CHANNELS-1, the scan order is 0, 1, …, CHANNELS-1.

## Configuration
- RR_MUX_COUNT_EN defined:
  - Adds output port xfer_count [15:0].
  - Counts output transfers (out_valid & out_ready) and saturates at 16'hFFFF.
  - Cleared by reset.
- Not defined: the port and the counter are absent, and behaviour is otherwise identical.

## Structure
- Shared package rr_mux_pkg holds:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1 constants
  - The default WIDTH/CHANNELS constants
- Sub-module rr_arbiter holds the rotating-priority find-first logic:
  - Inputs: req[CHANNELS], ptr
  - Outputs: gnt_valid, gnt_idx
  - Purely combinational
- The top level holds ptr, the output register and the optional counter.

## Test plan
All scenarios use WIDTH=8, CHANNELS=4, with ch0=8'hAA, ch1=8'h55, ch2=8'h0F, ch3=8'hF0.
- Fixed-mode parity with mux2: mode=0, all valid, out_ready=1, select toggles 0/1 every 10 cycles → out_data alternates 8'hAA/8'h55 one cycle after each toggle; only in_ready[select] is 1.
- Round-robin after reset: mode=1, all four valid, out_ready=1 → out_channel sequence 0,1,2,3,0,…; out_data sequence AA,55,0F,F0,AA.
- Skipping and wrap: mode=1, only ch1 and ch3 valid → channels 1,3,1,3; ptr wraps past 3 back to 1.
- Backpressure: FULL holding 8'h55, out_ready=0 for 5 cycles → out_data, out_channel and out_valid stable, in_ready=4'b0000; when out_ready=1, the next word appears on the following cycle with no loss.
- Invalid select and reset mid-stream: mode=0, select=3, in_valid[3]=0 → out_valid drops to 0 after the drain; then assert reset while FULL → next cycle out_valid=0, out_data=0, and the first round-robin grant goes to ch0.
- RR_MUX_COUNT_EN build: run 70000 transfers → xfer_count saturates at 16'hFFFF; after reset it reads 0.
